// File: rtl/inputs_botao_numero_aleatorio_if.sv
// Bus for the input-conditioning block: raw buttons and seeds in,
// registered direction and apple coordinates out.
interface inputs_botao_numero_aleatorio_if;
    logic       w;
    logic       a;
    logic       s;
    logic       d;
    logic [3:0] semente_x;
    logic [3:0] semente_y;
    logic [3:0] direcao;
    logic [3:0] aleatorio_x;
    logic [3:0] aleatorio_y;

    // Game core / stimulus side: drives buttons and seeds.
    modport master (
        output w,
        output a,
        output s,
        output d,
        output semente_x,
        output semente_y,
        input  direcao,
        input  aleatorio_x,
        input  aleatorio_y
    );

    // Conditioning block side.
    modport slave (
        input  w,
        input  a,
        input  s,
        input  d,
        input  semente_x,
        input  semente_y,
        output direcao,
        output aleatorio_x,
        output aleatorio_y
    );
endinterface

// File: rtl/inputs_botao_numero_aleatorio.sv
// Snake game input block: synchronizes W/A/S/D into a one-hot movement
// direction with reversal lock, and runs two independent 4-bit LFSRs that
// produce apple coordinates confined to the playfield interior (1..14).
module inputs_botao_numero_aleatorio (
    input logic                            clock,
    input logic                            reset_n,
    inputs_botao_numero_aleatorio_if.slave bus
);

    typedef enum logic [3:0] {
        Parado   = 4'b0000,
        Cima     = 4'b0001,
        Esquerda = 4'b0010,
        Baixo    = 4'b0100,
        Direita  = 4'b1000
    } direcao_t;

    // Button synchronizers.
    logic w_s1, w_s2;
    logic a_s1, a_s2;
    logic s_s1, s_s2;
    logic d_s1, d_s2;

    // Direction state.
    direcao_t estado;
    direcao_t estado_prox;
    direcao_t candidato;

    // Random generators.
    logic [3:0] lfsr_x, lfsr_x_prox;
    logic [3:0] lfsr_y, lfsr_y_prox;
    logic       carregado_x;
    logic       carregado_y;

    // One LFSR step; 1111 is skipped so the walk stays inside 1..14.
    function automatic logic [3:0] passo(input logic [3:0] q);
        logic [3:0] f;
        f = {q[2:0], q[3] ^ q[2]};
        if (f == 4'b1111) begin
            f = 4'b1110;
        end
        return f;
    endfunction

    // Seeds outside the interior are pulled onto the nearest legal value.
    function automatic logic [3:0] ajusta_semente(input logic [3:0] semente);
        logic [3:0] r;
        r = semente;
        if (semente == 4'b0000) begin
            r = 4'b0001;
        end else if (semente == 4'b1111) begin
            r = 4'b1110;
        end
        return r;
    endfunction

    // Two-flop synchronizers for the asynchronous button levels.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_s1 <= 1'b0;
            w_s2 <= 1'b0;
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            s_s1 <= 1'b0;
            s_s2 <= 1'b0;
            d_s1 <= 1'b0;
            d_s2 <= 1'b0;
        end else begin
            w_s1 <= bus.w;
            w_s2 <= w_s1;
            a_s1 <= bus.a;
            a_s2 <= a_s1;
            s_s1 <= bus.s;
            s_s2 <= s_s1;
            d_s1 <= bus.d;
            d_s2 <= d_s1;
        end
    end

    // Highest-priority pressed button (w > a > s > d) as a one-hot candidate.
    always_comb begin
        candidato = Parado;
        if (w_s2) begin
            candidato = Cima;
        end else if (a_s2) begin
            candidato = Esquerda;
        end else if (s_s2) begin
            candidato = Baixo;
        end else if (d_s2) begin
            candidato = Direita;
        end
    end

    // Next direction: accept the candidate unless it is empty or a reversal.
    always_comb begin
        estado_prox = estado;
        case (estado)
            Parado: begin
                if (candidato != Parado) begin
                    estado_prox = candidato;
                end
            end
            Cima: begin
                if (candidato != Parado && candidato != Baixo) begin
                    estado_prox = candidato;
                end
            end
            Baixo: begin
                if (candidato != Parado && candidato != Cima) begin
                    estado_prox = candidato;
                end
            end
            Esquerda: begin
                if (candidato != Parado && candidato != Direita) begin
                    estado_prox = candidato;
                end
            end
            Direita: begin
                if (candidato != Parado && candidato != Esquerda) begin
                    estado_prox = candidato;
                end
            end
            default: begin
                estado_prox = Parado;
            end
        endcase
    end

    // Direction register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= Parado;
        end else begin
            estado <= estado_prox;
        end
    end

    // X generator next state: seed on the first edge, LFSR step afterwards.
    always_comb begin
        lfsr_x_prox = lfsr_x;
        if (!carregado_x) begin
            lfsr_x_prox = ajusta_semente(bus.semente_x);
        end else begin
            lfsr_x_prox = passo(lfsr_x);
        end
    end

    // X generator state and load flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_x      <= 4'b0000;
            carregado_x <= 1'b0;
        end else begin
            lfsr_x      <= lfsr_x_prox;
            carregado_x <= 1'b1;
        end
    end

    // Y generator next state: seed on the first edge, LFSR step afterwards.
    always_comb begin
        lfsr_y_prox = lfsr_y;
        if (!carregado_y) begin
            lfsr_y_prox = ajusta_semente(bus.semente_y);
        end else begin
            lfsr_y_prox = passo(lfsr_y);
        end
    end

    // Y generator state and load flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_y      <= 4'b0000;
            carregado_y <= 1'b0;
        end else begin
            lfsr_y      <= lfsr_y_prox;
            carregado_y <= 1'b1;
        end
    end

    assign bus.direcao     = estado;
    assign bus.aleatorio_x = lfsr_x;
    assign bus.aleatorio_y = lfsr_y;

endmodule

// File: tb/tb_inputs_botao_numero_aleatorio.sv
// Bench for inputs_botao_numero_aleatorio: directed scenarios followed by
// random button/seed/reset activity, compared each edge against a reference
// model built from the direction rules and the published LFSR sequence.
module tb_inputs_botao_numero_aleatorio;

    logic clock;
    logic reset_n;

    inputs_botao_numero_aleatorio_if bus ();

    inputs_botao_numero_aleatorio dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks;
    int errors;

    // Reference sequence of the coordinate generator.
    logic [3:0] ref_seq [14];

    // Model state.
    logic [3:0] m_s1;
    logic [3:0] m_s2;
    logic [3:0] m_dir;
    int         m_ix;
    int         m_iy;
    bit         m_ld;

    function automatic logic [3:0] adj(input logic [3:0] v);
        if (v == 4'd0) return 4'd1;
        if (v == 4'd15) return 4'd14;
        return v;
    endfunction

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 14; i++) begin
            if (ref_seq[i] == v) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input logic [3:0] obs);
        checks++;
        assert (obs >= 4'd1 && obs <= 4'd14)
        else begin
            errors++;
            $error("FAIL %s observed %b expected 0001..1110", tag, obs);
        end
    endtask

    task automatic model_reset();
        m_s1  = 4'd0;
        m_s2  = 4'd0;
        m_dir = 4'd0;
        m_ix  = 0;
        m_iy  = 0;
        m_ld  = 1'b0;
    endtask

    // What one rising edge does, in terms of the behavioural rules.
    task automatic model_edge();
        logic [3:0] cand;
        logic [3:0] opposite;
        if (!reset_n) return;
        cand     = m_s2 & (~m_s2 + 4'd1);   // lowest set bit = highest priority
        opposite = {m_dir[1:0], m_dir[3:2]};
        if (cand != 4'd0 && cand != opposite) m_dir = cand;
        m_s2 = m_s1;
        m_s1 = {bus.d, bus.s, bus.a, bus.w};
        if (!m_ld) begin
            m_ix = idx_of(adj(bus.semente_x));
            m_iy = idx_of(adj(bus.semente_y));
            m_ld = 1'b1;
        end else begin
            m_ix = (m_ix + 1) % 14;
            m_iy = (m_iy + 1) % 14;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        chk("direcao", bus.direcao, m_dir);
        chk("aleatorio_x", bus.aleatorio_x, m_ld ? ref_seq[m_ix] : 4'd0);
        chk("aleatorio_y", bus.aleatorio_y, m_ld ? ref_seq[m_iy] : 4'd0);
    endtask

    task automatic buttons(input logic bw, input logic ba, input logic bs, input logic bd);
        bus.w = bw;
        bus.a = ba;
        bus.s = bs;
        bus.d = bd;
    endtask

    // Assert reset between edges, check the immediate clear, release later.
    task automatic do_reset(input logic [3:0] sx, input logic [3:0] sy);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("reset_direcao", bus.direcao, 4'd0);
        chk("reset_x", bus.aleatorio_x, 4'd0);
        chk("reset_y", bus.aleatorio_y, 4'd0);
        @(posedge clock);
        #1;
        chk("reset_hold_x", bus.aleatorio_x, 4'd0);
        bus.semente_x = sx;
        bus.semente_y = sy;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ref_seq = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13,
                    4'd10, 4'd5, 4'd11, 4'd7, 4'd14, 4'd12, 4'd8};
        reset_n = 1'b0;
        buttons(0, 0, 0, 0);
        bus.semente_x = 4'd1;
        bus.semente_y = 4'd11;
        model_reset();
        #2;
        chk("por_direcao", bus.direcao, 4'd0);
        chk("por_x", bus.aleatorio_x, 4'd0);
        chk("por_y", bus.aleatorio_y, 4'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Hold w: two edges of latency, then cima; release keeps it.
        buttons(1, 0, 0, 0);
        tick(); chk("w_edge1", bus.direcao, 4'b0000);
        chk("seed1_first_x", bus.aleatorio_x, 4'b0001);
        tick(); chk("w_edge2", bus.direcao, 4'b0000);
        tick(); chk("w_edge3", bus.direcao, 4'b0001);
        buttons(0, 0, 0, 0);
        repeat (4) tick();
        chk("w_release", bus.direcao, 4'b0001);

        // Reversal blocked, turn right, then left blocked.
        buttons(0, 0, 1, 0);
        repeat (4) tick();
        chk("s_blocked", bus.direcao, 4'b0001);
        buttons(0, 0, 0, 1);
        repeat (3) tick();
        chk("d_turn", bus.direcao, 4'b1000);
        buttons(0, 1, 0, 0);
        repeat (4) tick();
        chk("a_blocked", bus.direcao, 4'b1000);
        buttons(0, 0, 0, 0);

        // Seed 0001: exact sequence over 100 edges, never 0000/1111.
        repeat (100) begin
            tick();
            chk_range("x_range", bus.aleatorio_x);
        end

        // Priority from parado.
        buttons(0, 1, 0, 1);
        do_reset(4'd5, 4'd6);
        repeat (3) tick();
        chk("a_d_prio", bus.direcao, 4'b0010);
        buttons(1, 1, 1, 1);
        do_reset(4'd5, 4'd6);
        repeat (3) tick();
        chk("wasd_prio", bus.direcao, 4'b0001);
        buttons(0, 0, 0, 0);

        // Seeds 1011 / 1100.
        do_reset(4'b1011, 4'b1100);
        tick();
        chk("b_c_x0", bus.aleatorio_x, 4'b1011);
        chk("b_c_y0", bus.aleatorio_y, 4'b1100);
        tick();
        chk("b_c_x1", bus.aleatorio_x, 4'b0111);
        chk("b_c_y1", bus.aleatorio_y, 4'b1000);
        tick();
        chk("b_c_x2", bus.aleatorio_x, 4'b1110);
        chk("b_c_y2", bus.aleatorio_y, 4'b0001);

        // Illegal seeds are adjusted; later seed changes are ignored.
        do_reset(4'b0000, 4'b1111);
        tick();
        chk("seed0_x", bus.aleatorio_x, 4'b0001);
        chk("seed15_y", bus.aleatorio_y, 4'b1110);
        bus.semente_x = 4'd9;
        bus.semente_y = 4'd3;
        repeat (5) tick();

        // Mid-run reset clears at once and reloads on the first edge.
        do_reset(4'd7, 4'd13);
        tick();
        chk("reload_x", bus.aleatorio_x, 4'd7);
        chk("reload_y", bus.aleatorio_y, 4'd13);

        // Random buttons, seed changes and occasional resets.
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end else if (r < 6) begin
                bus.semente_x = 4'($urandom_range(0, 15));
                bus.semente_y = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 3) == 0) begin
                buttons(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            tick();
            if (m_ld) begin
                chk_range("rand_x_range", bus.aleatorio_x);
                chk_range("rand_y_range", bus.aleatorio_y);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inputs_botao_numero_aleatorio.md
# inputs_botao_numero_aleatorio

Input-conditioning and randomness block for the snake game core. It synchronizes the four W/A/S/D push-buttons into a registered one-hot movement direction. It also generates two independent pseudo-random 4-bit coordinates, X and Y, used to place the apple. All coordinates are kept inside the playfield interior (1..14), which excludes the wall rows and columns 0 and 15.

## Interface
- No parameters.
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `w`, `a`, `s`, `d`  in  1 each  raw, asynchronous button levels; 1 = pressed.
- `semente_x`  in  4  seed for the X generator; sampled once after reset.
- `semente_y`  in  4  seed for the Y generator; sampled once after reset.
- `direcao`  out  4  registered one-hot direction:
  - 0001 = cima (w)
  - 0010 = esquerda (a)
  - 0100 = baixo (s)
  - 1000 = direita (d)
  - 0000 = parado
- `aleatorio_x`  out  4  registered pseudo-random X coordinate, 1..14 after load.
- `aleatorio_y`  out  4  registered pseudo-random Y coordinate, 1..14 after load.

## Operation
- **Button path**
  - Each button passes through a 2-flop synchronizer (`*_s1` → `*_s2`).
  - The decode is level-sensitive on the `*_s2` values.
  - Priority when several buttons are high: w > a > s > d.
  - A candidate direction is the one-hot code of the highest-priority pressed button.
  - Reversal lock: a candidate exactly opposite to the current `direcao` is ignored and `direcao` holds. Opposite pairs are 0001/0100 and 0010/1000.
  - With no button pressed, `direcao` holds.
  - From 0000, any candidate is accepted.
- **Random path** (two identical instances, X and Y)
  - Each instance is a 4-bit Fibonacci LFSR with feedback f(q) = {q[2:0], q[3]^q[2]}.
  - `carregado` flag:
    - When 0 (first edge after reset): load the seed, then set the flag.
    - Seed 0000 loads as 0001.
    - Seed 1111 loads as 1110.
  - When the flag is 1, every edge sets q ← f(q). If f(q) = 1111, q ← f(1111) = 1110 instead.
  - The state space is therefore 1..14, period 14.
  - `aleatorio_*` = q (registered, no output logic).
  - The X and Y instances do not interact.
- **Reset values** (asynchronous, immediate on `reset_n` = 0)
  - `direcao` = 0000.
  - All synchronizer flops = 0.
  - LFSR q = 0000, so `aleatorio_*` = 0000.
  - `carregado` = 0.

## Timing
- **Button latency**
  - Button high before edge k → `_s1` at k, `_s2` at k+1, `direcao` updated at edge k+2.
  - Release follows the same path; `direcao` holds afterwards.
- **Seed load**
  - First rising edge with `reset_n` = 1 → `aleatorio_*` = seed (adjusted as above).
  - Each following edge advances one LFSR step.
- **Reference sequence** from seed 0001: 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1110, 1100, 1000, then back to 0001.
- **Changes after load**
  - Seed changes after the load are ignored until the next reset.
  - `reset_n` asserted mid-sequence clears immediately. After release, the seed is reloaded on the first edge.
- **Reset release**
  - Deassertion is synchronized internally by the team reset synchronizer or assumed clean.
  - No output may change except on `clock` edges after release.

## Test plan
- Reset, then hold `w` = 1 → `direcao` = 0000 for 2 edges, 0001 at the 3rd edge. Release `w` → `direcao` stays 0001.
- `direcao` = 0001, press `s` → stays 0001 (reversal blocked). Press `d` → 1000 after 3 edges. Press `a` → stays 1000.
- From 0000, assert `a` and `d` simultaneously → 0010. Assert `w`, `a`, `s`, `d` together from 0000 → 0001.
- `semente_x` = 0001 → `aleatorio_x` follows the 14-value reference sequence exactly and repeats; 0000 and 1111 never appear over 100 cycles.
- `semente_x` = 1011, `semente_y` = 1100 → first outputs after reset are 1011 / 1100, next 0111 / 1000, then 1110 / 0001.
- Seed 0000 → first output 0001. Seed 1111 → first output 1110. Assert `reset_n` = 0 mid-run → all outputs 0000 immediately; after release, reload on the first edge.
